// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_req_arbiter #(
   parameter int WIDTH     = 32,
   parameter bit PRIO_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_f,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_f,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_f,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [2:0] F_ILLEGAL = 3'b011;

   logic [1:0]       state;
   logic             prio;
   logic             grant_id;
   logic             any_valid;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [2:0]       sel_f;

   // Contention goes to prio; a lone requester always wins.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      grant_id  = req1_valid & (~req0_valid | prio);
      sel_a     = grant_id ? req1_a : req0_a;
      sel_b     = grant_id ? req1_b : req0_b;
      sel_f     = grant_id ? req1_f : req0_f;
   end

   assign req0_ready = ~reset & (state == S_IDLE) & req0_valid & ~grant_id;
   assign req1_ready = ~reset & (state == S_IDLE) & req1_valid &  grant_id;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         prio      <= PRIO_INIT;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_f     <= 3'b000;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_zero  <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_valid) begin
                  alu_a  <= sel_a;
                  alu_b  <= sel_b;
                  alu_f  <= sel_f;
                  rsp_id <= grant_id;
                  prio   <= ~grant_id;
                  // Illegal code skips the ALU cycle and answers with an error.
                  if (sel_f == F_ILLEGAL) begin
                     rsp_data  <= '0;
                     rsp_zero  <= 1'b0;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               rsp_data  <= alu_out;
               rsp_zero  <= alu_zero;
               rsp_err   <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - randomized self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;

   localparam int WIDTH     = 32;
   localparam bit PRIO_INIT = 1'b0;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]       req0_f, req1_f;
   logic [WIDTH-1:0] alu_a, alu_b, alu_out;
   logic [2:0]       alu_f;
   logic             alu_zero;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [WIDTH-1:0] rsp_data;

   int vectors = 0;
   int miscompares = 0;

   alu_req_arbiter #(.WIDTH(WIDTH), .PRIO_INIT(PRIO_INIT)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // Reference ALU; code 011 yields garbage that the block must never forward.
   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
      case (f)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b100:  return a & ~b;
         3'b101:  return a | ~b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'hdead_beef;
      endcase
   endfunction

   always_comb begin
      alu_out  = alu_fn(alu_a, alu_b, alu_f);
      alu_zero = (alu_out == 32'd0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Transaction-level model: at most one op outstanding, response due a fixed
   // number of cycles after the accept cycle.
   int          cyc = 0;
   int          acc_cyc = 0;
   int          lat = 0;
   bit          outst = 0;
   bit          prio_m = PRIO_INIT;
   bit          acc0, acc1;
   bit          e_id, e_zero, e_err;
   logic [31:0] e_data, e_a, e_b;
   logic [2:0]  e_f;

   task automatic step();
      bit g;
      bit due;
      @(negedge clk);
      acc0 = 0;
      acc1 = 0;
      if (!outst) begin
         g = (req0_valid && req1_valid) ? prio_m : req1_valid;
         check("req0_ready", req0_ready, req0_valid && !g);
         check("req1_ready", req1_ready, req1_valid && g);
         check("rsp_valid_idle", rsp_valid, 0);
         if (req0_valid || req1_valid) begin
            outst   = 1;
            acc_cyc = cyc;
            e_id    = g;
            e_a     = g ? req1_a : req0_a;
            e_b     = g ? req1_b : req0_b;
            e_f     = g ? req1_f : req0_f;
            e_err   = (e_f == 3'b011);
            lat     = e_err ? 1 : 2;
            e_data  = e_err ? 32'd0 : alu_fn(e_a, e_b, e_f);
            e_zero  = !e_err && (e_data == 32'd0);
            prio_m  = !g;
            acc0    = !g;
            acc1    = g;
         end
      end else begin
         check("req0_ready_busy", req0_ready, 0);
         check("req1_ready_busy", req1_ready, 0);
         check("alu_a", alu_a, e_a);
         check("alu_b", alu_b, e_b);
         check("alu_f", alu_f, e_f);
         due = (cyc >= acc_cyc + lat);
         check("rsp_valid", rsp_valid, due);
         if (due) begin
            check("rsp_id", rsp_id, e_id);
            check("rsp_data", rsp_data, e_data);
            check("rsp_zero", rsp_zero, e_zero);
            check("rsp_err", rsp_err, e_err);
            if (rsp_ready) outst = 0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_f", alu_f, 0);
      check("rst_rsp_data", rsp_data, 0);
      #2;
      reset  = 1'b0;
      outst  = 0;
      prio_m = PRIO_INIT;
   endtask

   task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f);
      if (n == 0) begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f;
      end else begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f;
      end
   endtask

   task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input int tail);
      bit done = 0;
      set_req(n, a, b, f);
      for (int i = 0; i < 10 && !done; i++) begin
         step();
         done = (n == 0) ? acc0 : acc1;
      end
      if (!done) check("accept_timeout", 0, 1);
      if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      for (int i = 0; i < tail; i++) step();
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_f = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_f = 0;
      rsp_ready  = 1'b1;
      @(posedge clk);
      #1;
      pulse_reset();

      issue(0, 32'd5, 32'd7, 3'b010, 3);

      // Both requesters stay valid; each accepted op is replaced by a new one.
      set_req(0, 32'd10, 32'd1, 3'b010);
      set_req(1, 32'd20, 32'd2, 3'b110);
      for (int i = 0; i < 13; i++) begin
         step();
         if (acc0) set_req(0, 32'd10 + i, 32'd1, 3'b010);
         if (acc1) set_req(1, 32'd20 + i, 32'd2, 3'b110);
      end
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 3; i++) step();

      issue(1, 32'd5,  32'd5,  3'b110, 3);
      issue(1, 32'd3,  32'd5,  3'b111, 3);
      issue(1, 32'd5,  32'd3,  3'b111, 3);
      issue(1, 32'hff, 32'h0f, 3'b100, 3);
      issue(1, 32'hffff_fffb, 32'd2, 3'b111, 3);

      issue(0, 32'd9,  32'd9,  3'b011, 0);
      issue(0, 32'hc,  32'ha,  3'b000, 3);

      // Consumer stalls while both requesters keep asking.
      rsp_ready = 1'b0;
      issue(0, 32'h1234, 32'h1, 3'b001, 0);
      set_req(0, 32'd1, 32'd1, 3'b010);
      set_req(1, 32'd2, 32'd2, 3'b010);
      for (int i = 0; i < 5; i++) step();
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 3; i++) step();

      // Reset while the op is in EXEC; priority must return to PRIO_INIT.
      issue(0, 32'd4, 32'd4, 3'b010, 0);
      set_req(0, 32'd7, 32'd1, 3'b110);
      set_req(1, 32'd8, 32'd1, 3'b110);
      pulse_reset();
      for (int i = 0; i < 6; i++) step();
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 3; i++) step();

      for (int i = 0; i < 1500; i++) begin
         if (acc0 || !req0_valid) begin
            if ($urandom_range(0, 1) == 1)
               set_req(0, ($urandom_range(0, 3) == 0) ? 32'd6 : $urandom,
                       ($urandom_range(0, 3) == 0) ? 32'd6 : $urandom, 3'($urandom_range(0, 7)));
            else
               req0_valid = 1'b0;
         end
         if (acc1 || !req1_valid) begin
            if ($urandom_range(0, 1) == 1)
               set_req(1, ($urandom_range(0, 3) == 0) ? 32'd6 : $urandom,
                       ($urandom_range(0, 3) == 0) ? 32'd6 : $urandom, 3'($urandom_range(0, 7)));
            else
               req1_valid = 1'b0;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) pulse_reset();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
